// File: rtl/uart_buf_pkg.sv
// Shared constants and helpers for the UART transmit buffer.
// Holds the tfi status-word bit map, the block version and the width helper.
package uart_buf_pkg;

    // tfi status word bit positions
    localparam int TFI_CNT_LSB = 0;
    localparam int TFI_CNT_W   = 16;
    localparam int TFI_EMPTY   = 16;
    localparam int TFI_FULL    = 17;
    localparam int TFI_PFULL   = 18;
    localparam int TFI_OVF     = 19;
    localparam int TFI_UDF     = 20;
    localparam int TFI_EN      = 21;
    localparam int TFI_VER_LSB = 24;

    localparam logic [7:0] TFI_VERSION = 8'h02;

    // ceil(log2(value)) + 1: counter width able to hold 0..value inclusive
    function automatic int clog2_plus1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock synchronous FIFO with registered read port.
// Memory, wrapping pointers, occupancy count and empty/full flags live here.
// A synchronous flush clears pointers and count without touching memory.
module uart_sync_fifo
    import uart_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int CW     = clog2_plus1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    localparam int AW = CW - 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wp_reg;
    logic [AW-1:0] rp_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          empty_reg;
    logic          full_reg;
    logic          wr_acc;
    logic          rd_acc;

    // Full blocks writes and empty blocks reads, so a simultaneous request on
    // an empty FIFO only writes and on a full FIFO only reads.
    assign wr_acc = push && !full_reg && !flush;
    assign rd_acc = pop && !empty_reg && !flush;

    // Next occupancy; a paired read and write leaves it unchanged
    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointer, count and flag registers with flush taking precedence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else if (flush) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp_reg <= wp_reg + AW'(1);
            end
            if (rd_acc) begin
                rp_reg <= rp_reg + AW'(1);
            end
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage array; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp_reg] <= wr_data;
        end
    end

    // Registered read port; rd_data holds between accepted reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rp_reg];
            end
        end
    end

    assign count = count_reg;
    assign empty = empty_reg;
    assign full  = full_reg;

endmodule

// File: rtl/uart_tx_buffer_param.sv
// UART monitor-path transmit buffer.
// Wraps the sync FIFO with a programmable full threshold, sticky
// overflow/underflow flags, flush while disabled and the tfi status word.
module uart_tx_buffer_param
    import uart_buf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int PFULL_TH = 240
) (
    input  logic              clk_125,
    input  logic              rst_125,
    input  logic              tx_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pfull_th_we,
    input  logic              sticky_clr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              prog_full,
    output logic [31:0]       tfi
);

    localparam int CW = clog2_plus1(DEPTH);

    logic          flush;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] count;
    logic [CW-1:0] threshold_reg;
    logic [CW-1:0] th_load;
    logic          ovf_reg;
    logic          udf_reg;
    logic          ovf_event;
    logic          udf_event;

    // A threshold load reuses the write strobe, so it must never also push
    assign flush     = !tx_en;
    assign fifo_push = wr_en && tx_en && !pfull_th_we;
    assign fifo_pop  = rd_en && tx_en;

    assign ovf_event = fifo_push && full;
    assign udf_event = fifo_pop && empty;

    // Low threshold bits; a zero would make prog_full permanently set, so use 1
    assign th_load = (CW'(wr_data) == '0) ? CW'(1) : CW'(wr_data);

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CW     (CW)
    ) u_fifo (
        .clk      (clk_125),
        .rst      (rst_125),
        .flush    (flush),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // Programmable-full threshold register, kept across flushes
    always_ff @(posedge clk_125 or posedge rst_125) begin
        if (rst_125) begin
            threshold_reg <= CW'(PFULL_TH);
        end else if (pfull_th_we) begin
            threshold_reg <= th_load;
        end
    end

    // Sticky error flags; a new event beats a concurrent clear
    always_ff @(posedge clk_125 or posedge rst_125) begin
        if (rst_125) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            if (ovf_event) begin
                ovf_reg <= 1'b1;
            end else if (sticky_clr) begin
                ovf_reg <= 1'b0;
            end
            if (udf_event) begin
                udf_reg <= 1'b1;
            end else if (sticky_clr) begin
                udf_reg <= 1'b0;
            end
        end
    end

    assign prog_full = (count >= threshold_reg);

    // Packed status word for the register bank, straight from the registers
    always_comb begin
        tfi = '0;
        tfi[TFI_CNT_LSB +: TFI_CNT_W] = TFI_CNT_W'(count);
        tfi[TFI_EMPTY]                = empty;
        tfi[TFI_FULL]                 = full;
        tfi[TFI_PFULL]                = prog_full;
        tfi[TFI_OVF]                  = ovf_reg;
        tfi[TFI_UDF]                  = udf_reg;
        tfi[TFI_EN]                   = tx_en;
        tfi[TFI_VER_LSB +: 8]         = TFI_VERSION;
    end

endmodule

// File: tb/tb_uart_tx_buffer_param.sv
// Self-checking bench for uart_tx_buffer_param (DATA_W=32, DEPTH=256).
// Stimulus pushes expected read words into a scoreboard queue; a negedge
// monitor pops and compares whenever rd_valid is presented.
module tb_uart_tx_buffer_param;

    logic        clk_125     = 1'b0;
    logic        rst_125     = 1'b1;
    logic        tx_en       = 1'b1;
    logic        wr_en       = 1'b0;
    logic [31:0] wr_data     = '0;
    logic        pfull_th_we = 1'b0;
    logic        sticky_clr  = 1'b0;
    logic        rd_en       = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic        prog_full;
    logic [31:0] tfi;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_q [$];
    logic [31:0] sb_q [$];
    logic        exp_pred      = 1'b0;
    logic        exp_valid_cur = 1'b0;

    uart_tx_buffer_param #(
        .DATA_W   (32),
        .DEPTH    (256),
        .PFULL_TH (240)
    ) dut (
        .clk_125     (clk_125),
        .rst_125     (rst_125),
        .tx_en       (tx_en),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .pfull_th_we (pfull_th_we),
        .sticky_clr  (sticky_clr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .prog_full   (prog_full),
        .tfi         (tfi)
    );

    always #5 clk_125 = ~clk_125;

    // Expected rd_valid for the current cycle: the prediction made one cycle earlier
    always @(posedge clk_125 or posedge rst_125) begin
        if (rst_125) exp_valid_cur <= 1'b0;
        else         exp_valid_cur <= exp_pred;
    end

    // Monitor: rd_valid timing every cycle, data on each valid
    always @(negedge clk_125) begin
        logic [31:0] exp_word;
        checks++;
        if (rd_valid !== exp_valid_cur) begin
            failures++;
            $display("FAIL rd_valid_timing actual=%0b required=%0b t=%0t", rd_valid, exp_valid_cur, $time);
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rd_data_unexpected actual=%h required=none t=%0t", rd_data, $time);
            end else begin
                exp_word = sb_q.pop_front();
                if (rd_data !== exp_word) begin
                    failures++;
                    $display("FAIL rd_data actual=%h required=%h t=%0t", rd_data, exp_word, $time);
                end else begin
                    $display("read ok data=%h t=%0t", rd_data, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end else begin
            $display("check ok %s value=%h", name, act);
        end
    endtask

    task automatic cycle();
        @(posedge clk_125);
        #1;
    endtask

    task automatic idle();
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        pfull_th_we = 1'b0;
        sticky_clr  = 1'b0;
        exp_pred    = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input bit expect_acc);
        wr_en   = 1'b1;
        wr_data = d;
        if (expect_acc) model_q.push_back(d);
        cycle();
        idle();
    endtask

    task automatic pop(input bit expect_acc);
        rd_en    = 1'b1;
        exp_pred = expect_acc;
        if (expect_acc) sb_q.push_back(model_q.pop_front());
        cycle();
        idle();
    endtask

    task automatic rw(input logic [31:0] d);
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        wr_data  = d;
        exp_pred = 1'b1;
        sb_q.push_back(model_q.pop_front());
        model_q.push_back(d);
        cycle();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk_125);
        #1;
        // Reset state
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_pfull", {31'b0, prog_full}, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_tfi", tfi, 32'h0221_0000);
        rst_125 = 1'b0;
        cycle();

        // 1: three writes then three reads
        push(32'hA5, 1);
        push(32'h5A, 1);
        push(32'hFF, 1);
        chk("t1_count", {16'h0, tfi[15:0]}, 32'd3);
        chk("t1_empty", {31'b0, empty}, 32'd0);
        pop(1);
        pop(1);
        pop(1);
        chk("t1_empty_after", {31'b0, empty}, 32'd1);
        chk("t1_count_after", {16'h0, tfi[15:0]}, 32'd0);

        // 2: fill, overflow, drain, sticky clear
        for (int i = 0; i < 256; i++) push(32'hC000_0000 + i, 1);
        chk("t2_full", {31'b0, full}, 32'd1);
        chk("t2_count", {16'h0, tfi[15:0]}, 32'd256);
        chk("t2_pfull", {31'b0, prog_full}, 32'd1);
        chk("t2_ovf_before", {31'b0, tfi[19]}, 32'd0);
        push(32'h1234, 0);
        chk("t2_ovf", {31'b0, tfi[19]}, 32'd1);
        chk("t2_count_ovf", {16'h0, tfi[15:0]}, 32'd256);
        for (int i = 0; i < 256; i++) pop(1);
        chk("t2_empty", {31'b0, empty}, 32'd1);
        chk("t2_ovf_kept", {31'b0, tfi[19]}, 32'd1);
        sticky_clr = 1'b1;
        cycle();
        idle();
        chk("t2_ovf_clr", {31'b0, tfi[19]}, 32'd0);

        // 3: programmable threshold
        pfull_th_we = 1'b1;
        wr_en       = 1'b1;
        wr_data     = 32'd4;
        cycle();
        idle();
        chk("t3_th_not_pushed", {16'h0, tfi[15:0]}, 32'd0);
        push(32'h31, 1);
        push(32'h32, 1);
        push(32'h33, 1);
        chk("t3_pfull_3", {31'b0, prog_full}, 32'd0);
        push(32'h34, 1);
        chk("t3_pfull_4", {31'b0, prog_full}, 32'd1);
        chk("t3_tfi_pfull", {31'b0, tfi[18]}, 32'd1);
        pop(1);
        chk("t3_pfull_drop", {31'b0, prog_full}, 32'd0);
        pop(1);
        pop(1);
        pop(1);
        pfull_th_we = 1'b1;
        wr_data     = 32'd0;
        cycle();
        idle();
        chk("t3_th0_cnt0", {31'b0, prog_full}, 32'd0);
        push(32'h77, 1);
        chk("t3_th0_cnt1", {31'b0, prog_full}, 32'd1);
        pop(1);

        // 4: simultaneous read/write, including on empty and across wrap
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        wr_data  = 32'hD0D0_0000;
        exp_pred = 1'b0;
        model_q.push_back(32'hD0D0_0000);
        cycle();
        idle();
        chk("t4_empty_rw_count", {16'h0, tfi[15:0]}, 32'd1);
        chk("t4_empty_rw_empty", {31'b0, empty}, 32'd0);
        push(32'hD0D0_0001, 1);
        for (int k = 0; k < 300; k++) begin
            rw(32'hD000_1000 + k);
            if (k % 100 == 99) chk("t4_count_hold", {16'h0, tfi[15:0]}, 32'd2);
        end
        pop(1);
        pop(1);
        chk("t4_empty", {31'b0, empty}, 32'd1);

        // 5: flush with tx_en low
        pop(0);
        chk("t5_udf", {31'b0, tfi[20]}, 32'd1);
        for (int i = 0; i < 5; i++) push(32'hF500 + i, 1);
        tx_en   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        cycle();
        model_q.delete();
        idle();
        chk("t5_flush_count", {16'h0, tfi[15:0]}, 32'd0);
        chk("t5_flush_empty", {31'b0, empty}, 32'd1);
        chk("t5_udf_kept", {31'b0, tfi[20]}, 32'd1);
        chk("t5_ovf_kept", {31'b0, tfi[19]}, 32'd0);
        chk("t5_tfi_en", {31'b0, tfi[21]}, 32'd0);
        tx_en = 1'b1;
        push(32'h5555_0001, 1);
        chk("t5_first_write", {16'h0, tfi[15:0]}, 32'd1);
        pop(1);

        // 6: asynchronous reset mid-burst
        push(32'hE0, 1);
        push(32'hE1, 1);
        push(32'hE2, 1);
        rd_en    = 1'b1;
        exp_pred = 1'b1;
        sb_q.push_back(model_q.pop_front());
        @(posedge clk_125);
        #3;
        rst_125  = 1'b1;
        rd_en    = 1'b0;
        exp_pred = 1'b0;
        sb_q.delete();
        model_q.delete();
        #1;
        chk("t6_rst_empty", {31'b0, empty}, 32'd1);
        chk("t6_rst_valid", {31'b0, rd_valid}, 32'd0);
        chk("t6_rst_rd_data", rd_data, 32'd0);
        chk("t6_rst_tfi", tfi, 32'h0221_0000);
        @(negedge clk_125);
        rst_125 = 1'b0;
        cycle();
        for (int i = 0; i < 239; i++) push(32'hB000_0000 + i, 1);
        chk("t6_pfull_239", {31'b0, prog_full}, 32'd0);
        push(32'hB000_00EF, 1);
        chk("t6_pfull_240", {31'b0, prog_full}, 32'd1);
        chk("t6_count_240", {16'h0, tfi[15:0]}, 32'd240);
        tx_en = 1'b0;
        cycle();
        model_q.delete();
        tx_en = 1'b1;
        chk("t6_flush_empty", {31'b0, empty}, 32'd1);
        pop(0);
        chk("t6_udf", {31'b0, tfi[20]}, 32'd1);
        sticky_clr = 1'b1;
        cycle();
        idle();
        chk("t6_udf_clr", {31'b0, tfi[20]}, 32'd0);
        sticky_clr = 1'b1;
        rd_en      = 1'b1;
        exp_pred   = 1'b0;
        cycle();
        idle();
        chk("t6_udf_wins", {31'b0, tfi[20]}, 32'd1);

        repeat (3) cycle();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
